config_mode_controller: RTL

CONFIG_MODE_CONTROLLER -- requirements
Module: config_mode_controller

---
 rtl/config_mode_controller.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/config_mode_controller.sv
// Configuration-mode controller: edits BCD fields of a selected function and requests a write.
// Latency: every command or button pulse takes effect on the next rising clock edge.
// Backpressure: wr_req stays high and the edit fields stay frozen until wr_ack or cfg_cancel.
module config_mode_controller (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] cfg_sel,
  input  logic       cfg_enter,
  input  logic       cfg_exit,
  input  logic       cfg_cancel,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic [7:0] live_f2,
  input  logic [7:0] live_f1,
  input  logic [7:0] live_f0,
  input  logic       wr_ack,
  output logic [7:0] edit_f2,
  output logic [7:0] edit_f1,
  output logic [7:0] edit_f0,
  output logic [1:0] funcion,
  output logic [1:0] cursor_location,
  output logic       wr_req,
  output logic [1:0] wr_sel
);

  typedef enum logic [1:0] {IDLE = 2'd0, EDIT = 2'd1, WRITE = 2'd2} state_t;

  state_t     state_q;
  logic [1:0] funcion_q;
  logic [1:0] cursor_q;
  logic [1:0] wr_sel_q;
  logic       wr_req_q;
  logic [7:0] f2_q, f1_q, f0_q;

  logic [7:0] cur_val;
  logic [7:0] step_val;
  logic [1:0] cursor_d;

  // Lower bound of a field: fecha day and month start at 01, everything else at 00.
  function automatic logic [7:0] fld_min(input logic [1:0] fn, input logic [1:0] idx);
    if (fn == 2'd2 && idx != 2'd0) return 8'h01;
    return 8'h00;
  endfunction

  // Upper bound of a field in BCD.
  function automatic logic [7:0] fld_max(input logic [1:0] fn, input logic [1:0] idx);
    if (fn == 2'd2) begin
      if (idx == 2'd2) return 8'h31;
      if (idx == 2'd1) return 8'h12;
      return 8'h99;
    end
    if (idx == 2'd2) return 8'h23;
    return 8'h59;
  endfunction

  // A live value is taken as-is only when both nibbles are decimal digits and it lies in range.
  // For valid BCD the byte ordering equals the decimal ordering, so plain compares suffice.
  function automatic logic [7:0] clamp_load(input logic [1:0] fn, input logic [1:0] idx,
                                            input logic [7:0] v);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = fld_min(fn, idx);
    hi = fld_max(fn, idx);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return lo;
    if (v < lo || v > hi) return lo;
    return v;
  endfunction

  // BCD increment with wrap from the field maximum to its minimum.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                         input logic [7:0] hi);
    if (v == hi) return lo;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // BCD decrement with wrap from the field minimum to its maximum.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo,
                                         input logic [7:0] hi);
    if (v == lo) return hi;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Value step and cursor move requested by this cycle's buttons (opposing pulses cancel).
  always_comb begin
    cur_val  = f0_q;
    step_val = f0_q;
    cursor_d = cursor_q;
    case (cursor_q)
      2'd2:    cur_val = f2_q;
      2'd1:    cur_val = f1_q;
      default: cur_val = f0_q;
    endcase
    step_val = cur_val;
    if (up && !down) begin
      step_val = bcd_inc(cur_val, fld_min(funcion_q, cursor_q), fld_max(funcion_q, cursor_q));
    end else if (down && !up) begin
      step_val = bcd_dec(cur_val, fld_min(funcion_q, cursor_q), fld_max(funcion_q, cursor_q));
    end
    if (left && !right) begin
      cursor_d = (cursor_q == 2'd2) ? 2'd0 : cursor_q + 2'd1;
    end else if (right && !left) begin
      cursor_d = (cursor_q == 2'd0) ? 2'd2 : cursor_q - 2'd1;
    end
  end

  // Mode FSM with all outputs registered; cancel outranks exit, exit outranks buttons.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      funcion_q <= 2'd0;
      cursor_q  <= 2'd2;
      wr_req_q  <= 1'b0;
      wr_sel_q  <= 2'd0;
      f2_q      <= 8'h00;
      f1_q      <= 8'h00;
      f0_q      <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_enter && cfg_sel != 2'd0) begin
            state_q   <= EDIT;
            funcion_q <= cfg_sel;
            cursor_q  <= 2'd2;
            f2_q      <= clamp_load(cfg_sel, 2'd2, live_f2);
            f1_q      <= clamp_load(cfg_sel, 2'd1, live_f1);
            f0_q      <= clamp_load(cfg_sel, 2'd0, live_f0);
          end
        end
        EDIT: begin
          if (cfg_cancel) begin
            state_q   <= IDLE;
            funcion_q <= 2'd0;
          end else if (cfg_exit) begin
            state_q  <= WRITE;
            wr_req_q <= 1'b1;
            wr_sel_q <= funcion_q;
          end else begin
            // The value step lands on the field under the old cursor, then the cursor moves.
            case (cursor_q)
              2'd2:    f2_q <= step_val;
              2'd1:    f1_q <= step_val;
              default: f0_q <= step_val;
            endcase
            cursor_q <= cursor_d;
          end
        end
        WRITE: begin
          if (cfg_cancel || wr_ack) begin
            state_q   <= IDLE;
            funcion_q <= 2'd0;
            wr_req_q  <= 1'b0;
            wr_sel_q  <= 2'd0;
          end
        end
        default: begin
          state_q   <= IDLE;
          funcion_q <= 2'd0;
          wr_req_q  <= 1'b0;
          wr_sel_q  <= 2'd0;
        end
      endcase
    end
  end

  assign edit_f2         = f2_q;
  assign edit_f1         = f1_q;
  assign edit_f0         = f0_q;
  assign funcion         = funcion_q;
  assign cursor_location = cursor_q;
  assign wr_req          = wr_req_q;
  assign wr_sel          = wr_sel_q;

endmodule
